// File: rtl/rs_pkg.sv
// rs_pkg: shared types and system constants for the reservation-station bank.
// Entry storage layout, the resolved dispatch slot and the CDB packet seen by
// every entry all live here so the bank, its entries and the bench agree.
package rs_pkg;

  localparam int         ROBLEN    = 32;
  localparam int         XLEN      = 32;
  localparam logic [4:0] ZERO_REG  = 5'd0;
  localparam int         TAG_W     = $clog2(ROBLEN);
  localparam int         PAYLOAD_W = 96;

  // One completion broadcast channel.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] T;
    logic [XLEN-1:0]  value;
  } CDB_RS_PACKET;

  // One registered reservation-station entry.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     T;
    logic [TAG_W-1:0]     T1;
    logic [TAG_W-1:0]     T2;
    logic                 rdy1;
    logic                 rdy2;
    logic [XLEN-1:0]      V1;
    logic [XLEN-1:0]      V2;
    logic [PAYLOAD_W-1:0] payload;
  } RS_ENTRY;

  // One dispatch slot as presented by the dispatch stage.
  typedef struct packed {
    logic                      valid;
    logic [TAG_W-1:0]          T;
    logic [4:0]                dest_reg;
    logic [1:0]                src_used;
    logic [1:0]                src_busy;
    logic [1:0]                src_plus;
    logic [1:0][4:0]           src_reg;
    logic [1:0][TAG_W-1:0]     src_tag;
    logic [1:0][XLEN-1:0]      src_value;
    logic [PAYLOAD_W-1:0]      payload;
  } DP_RS_SLOT;

endpackage

// File: rtl/rs_bank_if.sv
// rs_bank_if: dispatch, CDB and issue bundle of the reservation-station bank.
// slave is the bank side, master is the dispatch/FU (or bench) side.
interface rs_bank_if #(
  parameter int RS_DEPTH    = 8,
  parameter int DP_WIDTH    = 3,
  parameter int CDB_WIDTH   = 3,
  parameter int ISSUE_WIDTH = 2
) ();

  logic                                                     squash;
  logic [DP_WIDTH-1:0]                                      dp_valid;
  logic [DP_WIDTH-1:0][rs_pkg::TAG_W-1:0]                   dp_T;
  logic [DP_WIDTH-1:0][4:0]                                 dp_dest_reg;
  logic [DP_WIDTH-1:0][1:0]                                 dp_src_used;
  logic [DP_WIDTH-1:0][1:0]                                 dp_src_busy;
  logic [DP_WIDTH-1:0][1:0]                                 dp_src_plus;
  logic [DP_WIDTH-1:0][1:0][4:0]                            dp_src_reg;
  logic [DP_WIDTH-1:0][1:0][rs_pkg::TAG_W-1:0]              dp_src_tag;
  logic [DP_WIDTH-1:0][1:0][rs_pkg::XLEN-1:0]               dp_src_value;
  logic [DP_WIDTH-1:0][rs_pkg::PAYLOAD_W-1:0]               dp_payload;
  logic [CDB_WIDTH-1:0]                                     cdb_valid;
  logic [CDB_WIDTH-1:0][rs_pkg::TAG_W-1:0]                  cdb_tag;
  logic [CDB_WIDTH-1:0][rs_pkg::XLEN-1:0]                   cdb_value;
  logic [$clog2(RS_DEPTH+1)-1:0]                            free_count;
  logic                                                     dp_stall;
  logic [ISSUE_WIDTH-1:0]                                   issue_valid;
  logic [ISSUE_WIDTH-1:0][rs_pkg::TAG_W-1:0]                issue_T;
  logic [ISSUE_WIDTH-1:0][rs_pkg::XLEN-1:0]                 issue_V1;
  logic [ISSUE_WIDTH-1:0][rs_pkg::XLEN-1:0]                 issue_V2;
  logic [ISSUE_WIDTH-1:0][rs_pkg::PAYLOAD_W-1:0]            issue_payload;

  modport slave (
    input  squash, dp_valid, dp_T, dp_dest_reg, dp_src_used, dp_src_busy,
           dp_src_plus, dp_src_reg, dp_src_tag, dp_src_value, dp_payload,
           cdb_valid, cdb_tag, cdb_value,
    output free_count, dp_stall, issue_valid, issue_T, issue_V1, issue_V2,
           issue_payload
  );

  modport master (
    output squash, dp_valid, dp_T, dp_dest_reg, dp_src_used, dp_src_busy,
           dp_src_plus, dp_src_reg, dp_src_tag, dp_src_value, dp_payload,
           cdb_valid, cdb_tag, cdb_value,
    input  free_count, dp_stall, issue_valid, issue_T, issue_V1, issue_V2,
           issue_payload
  );

endinterface

// File: rtl/rs_entry.sv
// rs_entry: a single reservation-station entry. Holds the operands, snoops
// the CDB to wake waiting operands and reports when it is ready to issue.
module rs_entry
  import rs_pkg::*;
#(
  parameter int CDB_WIDTH = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            i_squash,
  input  logic                            i_alloc,
  input  logic                            i_issue,
  input  RS_ENTRY                         i_new,
  input  CDB_RS_PACKET [CDB_WIDTH-1:0]    i_cdb,
  output logic                            o_valid,
  output logic                            o_eligible,
  output logic [TAG_W-1:0]                o_T,
  output logic [XLEN-1:0]                 o_V1,
  output logic [XLEN-1:0]                 o_V2,
  output logic [PAYLOAD_W-1:0]            o_payload
);

  RS_ENTRY r_entry;
  RS_ENTRY w_next;

  // Next entry contents: wakeup (lowest channel wins), then issue clear, then a new allocation.
  always_comb begin
    w_next = r_entry;
    for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
      if (r_entry.valid && i_cdb[c].valid) begin
        if (!r_entry.rdy1 && (i_cdb[c].T == r_entry.T1)) begin
          w_next.rdy1 = 1'b1;
          w_next.V1   = i_cdb[c].value;
        end
        if (!r_entry.rdy2 && (i_cdb[c].T == r_entry.T2)) begin
          w_next.rdy2 = 1'b1;
          w_next.V2   = i_cdb[c].value;
        end
      end
    end
    if (i_issue) begin
      w_next.valid = 1'b0;
    end
    if (i_alloc) begin
      w_next = i_new;
    end
  end

  // Entry register; squash empties the entry regardless of dispatch or wakeup.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_entry <= '0;
    end else if (i_squash) begin
      r_entry <= '0;
    end else begin
      r_entry <= w_next;
    end
  end

  assign o_valid    = r_entry.valid;
  assign o_eligible = r_entry.valid & r_entry.rdy1 & r_entry.rdy2;
  assign o_T        = r_entry.T;
  assign o_V1       = r_entry.V1;
  assign o_V2       = r_entry.V2;
  assign o_payload  = r_entry.payload;

endmodule

// File: rtl/rs_bank.sv
// rs_bank: bank of RS_DEPTH reservation-station entries. Allocates up to
// DP_WIDTH dispatched instructions per cycle (resolving dependences inside
// the group), wakes operands from the CDB and issues up to ISSUE_WIDTH ready
// entries. Optional macro RS_AGE_PRIORITY_EN: keep an age matrix and issue
// oldest-first; without it, the lowest-index ready entries issue first.
module rs_bank
  import rs_pkg::*;
#(
  parameter int RS_DEPTH    = 8,
  parameter int DP_WIDTH    = 3,
  parameter int CDB_WIDTH   = 3,
  parameter int ISSUE_WIDTH = 2
) (
  input logic      clock,
  input logic      reset,
  rs_bank_if.slave bus
);

  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  DP_RS_SLOT    [DP_WIDTH-1:0]              w_slot;
  CDB_RS_PACKET [CDB_WIDTH-1:0]             w_cdb;
  logic [DP_WIDTH-1:0][1:0]                 w_srcRdy;
  logic [DP_WIDTH-1:0][1:0][TAG_W-1:0]      w_srcTag;
  logic [DP_WIDTH-1:0][1:0][XLEN-1:0]       w_srcVal;
  RS_ENTRY [DP_WIDTH-1:0]                   w_resolved;
  RS_ENTRY [RS_DEPTH-1:0]                   w_newEntry;
  logic [RS_DEPTH-1:0]                      w_entryValid, w_eligible;
  logic [RS_DEPTH-1:0]                      w_alloc, w_issue, w_cand;
  logic [RS_DEPTH-1:0][TAG_W-1:0]           w_entryT;
  logic [RS_DEPTH-1:0][XLEN-1:0]            w_entryV1, w_entryV2;
  logic [RS_DEPTH-1:0][PAYLOAD_W-1:0]       w_entryPayload;
  logic [CNT_W-1:0]                         w_freeCount;
  logic                                     w_stall, w_allocDone, w_found, w_older;

`ifdef RS_AGE_PRIORITY_EN
  localparam int SLOT_W = (DP_WIDTH > 1) ? $clog2(DP_WIDTH) : 1;
  logic [RS_DEPTH-1:0][SLOT_W-1:0]          w_allocSlot;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]        r_age;
`endif

  // Gather the flat bus signals into slot and CDB structs.
  always_comb begin
    w_slot = '0;
    w_cdb  = '0;
    for (int k = 0; k < DP_WIDTH; k++) begin
      w_slot[k].valid     = bus.dp_valid[k];
      w_slot[k].T         = bus.dp_T[k];
      w_slot[k].dest_reg  = bus.dp_dest_reg[k];
      w_slot[k].src_used  = bus.dp_src_used[k];
      w_slot[k].src_busy  = bus.dp_src_busy[k];
      w_slot[k].src_plus  = bus.dp_src_plus[k];
      w_slot[k].src_reg   = bus.dp_src_reg[k];
      w_slot[k].src_tag   = bus.dp_src_tag[k];
      w_slot[k].src_value = bus.dp_src_value[k];
      w_slot[k].payload   = bus.dp_payload[k];
    end
    for (int c = 0; c < CDB_WIDTH; c++) begin
      w_cdb[c].valid = bus.cdb_valid[c];
      w_cdb[c].T     = bus.cdb_tag[c];
      w_cdb[c].value = bus.cdb_value[c];
    end
  end

  // Source resolution, written lowest priority first so later rules override earlier ones.
  always_comb begin
    w_srcRdy = '0;
    w_srcTag = '0;
    w_srcVal = '0;
    for (int k = 0; k < DP_WIDTH; k++) begin
      for (int s = 0; s < 2; s++) begin
        w_srcTag[k][s] = w_slot[k].src_tag[s];
        w_srcVal[k][s] = w_slot[k].src_value[s];
        for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
          if (w_cdb[c].valid && (w_cdb[c].T == w_slot[k].src_tag[s])) begin
            w_srcRdy[k][s] = 1'b1;
            w_srcVal[k][s] = w_cdb[c].value;
          end
        end
        if (!w_slot[k].src_busy[s] || w_slot[k].src_plus[s]) begin
          w_srcRdy[k][s] = 1'b1;
          w_srcVal[k][s] = w_slot[k].src_value[s];
        end
        for (int j = 0; j < k; j++) begin
          if (w_slot[j].valid && (w_slot[j].dest_reg == w_slot[k].src_reg[s]) &&
              (w_slot[k].src_reg[s] != ZERO_REG)) begin
            w_srcRdy[k][s] = 1'b0;
            w_srcTag[k][s] = w_slot[j].T;
          end
        end
        if (!w_slot[k].src_used[s] || (w_slot[k].src_reg[s] == ZERO_REG)) begin
          w_srcRdy[k][s] = 1'b1;
          w_srcVal[k][s] = w_slot[k].src_value[s];
        end
      end
    end
  end

  // Build the entry image each slot would write.
  always_comb begin
    w_resolved = '0;
    for (int k = 0; k < DP_WIDTH; k++) begin
      w_resolved[k].valid   = 1'b1;
      w_resolved[k].T       = w_slot[k].T;
      w_resolved[k].T1      = w_srcTag[k][0];
      w_resolved[k].T2      = w_srcTag[k][1];
      w_resolved[k].rdy1    = w_srcRdy[k][0];
      w_resolved[k].rdy2    = w_srcRdy[k][1];
      w_resolved[k].V1      = w_srcVal[k][0];
      w_resolved[k].V2      = w_srcVal[k][1];
      w_resolved[k].payload = w_slot[k].payload;
    end
  end

  // Free-entry count from registered state and the resulting dispatch stall.
  always_comb begin
    w_freeCount = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_freeCount = w_freeCount + CNT_W'(!w_entryValid[i]);
    end
    w_stall = (int'(w_freeCount) < DP_WIDTH);
  end

  // Allocation: valid slot k takes the k-th lowest-index free entry.
  always_comb begin
    w_alloc     = '0;
    w_newEntry  = '0;
    w_allocDone = 1'b0;
`ifdef RS_AGE_PRIORITY_EN
    w_allocSlot = '0;
`endif
    for (int k = 0; k < DP_WIDTH; k++) begin
      w_allocDone = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (!w_stall && w_slot[k].valid && !w_allocDone && !w_entryValid[i] && !w_alloc[i]) begin
          w_alloc[i]    = 1'b1;
          w_newEntry[i] = w_resolved[k];
          w_allocDone   = 1'b1;
`ifdef RS_AGE_PRIORITY_EN
          w_allocSlot[i] = SLOT_W'(k);
`endif
        end
      end
    end
  end

`ifdef RS_AGE_PRIORITY_EN
  // Age matrix: r_age[a][b] set means entry a is older than entry b; new entries are youngest, in slot order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_age <= '0;
    end else if (!bus.squash) begin
      for (int a = 0; a < RS_DEPTH; a++) begin
        for (int b = 0; b < RS_DEPTH; b++) begin
          if (a != b) begin
            if (w_alloc[a] && w_alloc[b]) begin
              r_age[a][b] <= (w_allocSlot[a] < w_allocSlot[b]);
            end else if (w_alloc[a]) begin
              r_age[a][b] <= 1'b0;
            end else if (w_alloc[b]) begin
              r_age[a][b] <= 1'b1;
            end
          end
        end
      end
    end
  end
`endif

  // Issue selection and port drive; only registered state feeds this block.
  always_comb begin
    w_issue           = '0;
    w_cand            = w_eligible;
    w_found           = 1'b0;
    w_older           = 1'b0;
    bus.issue_valid   = '0;
    bus.issue_T       = '0;
    bus.issue_V1      = '0;
    bus.issue_V2      = '0;
    bus.issue_payload = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      w_found = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        w_older = 1'b0;
`ifdef RS_AGE_PRIORITY_EN
        for (int j = 0; j < RS_DEPTH; j++) begin
          if ((j != i) && w_cand[j] && r_age[j][i]) begin
            w_older = 1'b1;
          end
        end
`endif
        if (!w_found && w_cand[i] && !w_older) begin
          w_found              = 1'b1;
          w_cand[i]            = 1'b0;
          w_issue[i]           = 1'b1;
          bus.issue_valid[p]   = 1'b1;
          bus.issue_T[p]       = w_entryT[i];
          bus.issue_V1[p]      = w_entryV1[i];
          bus.issue_V2[p]      = w_entryV2[i];
          bus.issue_payload[p] = w_entryPayload[i];
        end
      end
    end
  end

  assign bus.free_count = w_freeCount;
  assign bus.dp_stall   = w_stall;

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_entry
    rs_entry #(.CDB_WIDTH(CDB_WIDTH)) u_entry (
      .clock      (clock),
      .reset      (reset),
      .i_squash   (bus.squash),
      .i_alloc    (w_alloc[g]),
      .i_issue    (w_issue[g]),
      .i_new      (w_newEntry[g]),
      .i_cdb      (w_cdb),
      .o_valid    (w_entryValid[g]),
      .o_eligible (w_eligible[g]),
      .o_T        (w_entryT[g]),
      .o_V1       (w_entryV1[g]),
      .o_V2       (w_entryV2[g]),
      .o_payload  (w_entryPayload[g])
    );
  end

endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: randomized bench for rs_bank against a behavioural model that
// tracks entries as a plain array with a dispatch sequence number for age.
// Follows RS_AGE_PRIORITY_EN the same way the design does.
module tb_rs_bank;
  import rs_pkg::*;

  localparam int RS_DEPTH    = 8;
  localparam int DP_WIDTH    = 3;
  localparam int CDB_WIDTH   = 3;
  localparam int ISSUE_WIDTH = 2;
  localparam int NUM_CYCLES  = 2000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rs_bank_if #(.RS_DEPTH(RS_DEPTH), .DP_WIDTH(DP_WIDTH), .CDB_WIDTH(CDB_WIDTH),
               .ISSUE_WIDTH(ISSUE_WIDTH)) bus ();

  rs_bank #(.RS_DEPTH(RS_DEPTH), .DP_WIDTH(DP_WIDTH), .CDB_WIDTH(CDB_WIDTH),
            .ISSUE_WIDTH(ISSUE_WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        valid;
    bit [4:0]  T;
    bit [4:0]  t1;
    bit [4:0]  t2;
    bit        r1;
    bit        r2;
    bit [31:0] v1;
    bit [31:0] v2;
    bit [95:0] pay;
    int        age;
  } mEnt_t;

  mEnt_t m[RS_DEPTH];
  int    ageCnt = 0;
  int    picks[$];
  int    errors = 0;
  int    checks = 0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < RS_DEPTH; i++) m[i].valid = 1'b0;
    ageCnt = 0;
  endtask

  task automatic applyIdle();
    bus.squash       = 1'b0;
    bus.dp_valid     = '0;
    bus.dp_T         = '0;
    bus.dp_dest_reg  = '0;
    bus.dp_src_used  = '0;
    bus.dp_src_busy  = '0;
    bus.dp_src_plus  = '0;
    bus.dp_src_reg   = '0;
    bus.dp_src_tag   = '0;
    bus.dp_src_value = '0;
    bus.dp_payload   = '0;
    bus.cdb_valid    = '0;
    bus.cdb_tag      = '0;
    bus.cdb_value    = '0;
  endtask

  task automatic applyStimulus(input bit doSquash);
    bit [4:0] pool[$];
    bus.squash = doSquash;
    for (int k = 0; k < DP_WIDTH; k++) begin
      bus.dp_valid[k]    = 1'($urandom_range(0, 1));
      bus.dp_T[k]        = 5'($urandom);
      bus.dp_dest_reg[k] = 5'($urandom_range(0, 7));
      bus.dp_payload[k]  = {$urandom, $urandom, $urandom};
      for (int s = 0; s < 2; s++) begin
        bus.dp_src_used[k][s]  = ($urandom_range(0, 4) != 0);
        bus.dp_src_busy[k][s]  = ($urandom_range(0, 9) < 6);
        bus.dp_src_plus[k][s]  = ($urandom_range(0, 9) < 2);
        bus.dp_src_reg[k][s]   = 5'($urandom_range(0, 7));
        bus.dp_src_tag[k][s]   = 5'($urandom);
        bus.dp_src_value[k][s] = $urandom;
        pool.push_back(bus.dp_src_tag[k][s]);
      end
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (m[i].valid && !m[i].r1) pool.push_back(m[i].t1);
      if (m[i].valid && !m[i].r2) pool.push_back(m[i].t2);
    end
    for (int c = 0; c < CDB_WIDTH; c++) begin
      bus.cdb_valid[c] = ($urandom_range(0, 2) != 0);
      bus.cdb_tag[c]   = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, pool.size() - 1)]
                                                     : 5'($urandom);
      bus.cdb_value[c] = $urandom;
    end
    if ($urandom_range(0, 5) == 0) bus.cdb_tag[CDB_WIDTH-1] = bus.cdb_tag[0];
  endtask

  // Lowest valid CDB channel carrying the tag, if any.
  function automatic bit cdbHit(input bit [4:0] tag, output bit [31:0] val);
    val = '0;
    for (int c = 0; c < CDB_WIDTH; c++) begin
      if (bus.cdb_valid[c] && (bus.cdb_tag[c] == tag)) begin
        val = bus.cdb_value[c];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void resolveSrc(input int k, input int s, output bit rdy,
                                     output bit [4:0] tag, output bit [31:0] val);
    bit [4:0] r    = bus.dp_src_reg[k][s];
    int       prod = -1;
    bit [31:0] cv;
    rdy = 1'b0;
    tag = bus.dp_src_tag[k][s];
    val = bus.dp_src_value[k][s];
    if (!bus.dp_src_used[k][s] || r == 5'd0) begin
      rdy = 1'b1;
      return;
    end
    for (int j = 0; j < k; j++) begin
      if (bus.dp_valid[j] && bus.dp_dest_reg[j] == r) prod = j;
    end
    if (prod >= 0) begin
      tag = bus.dp_T[prod];
      return;
    end
    if (!bus.dp_src_busy[k][s] || bus.dp_src_plus[k][s]) begin
      rdy = 1'b1;
      return;
    end
    if (cdbHit(tag, cv)) begin
      rdy = 1'b1;
      val = cv;
    end
  endfunction

  // Compare outputs with what the model predicts from its current state.
  task automatic checkCycle();
    int fc = 0;
    bit used[RS_DEPTH];
    picks.delete();
    for (int i = 0; i < RS_DEPTH; i++) if (!m[i].valid) fc++;
    checkOutput("free_count", bus.free_count, fc);
    checkOutput("dp_stall", bus.dp_stall, (fc < DP_WIDTH));
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      int best = -1;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (m[i].valid && m[i].r1 && m[i].r2 && !used[i]) begin
`ifdef RS_AGE_PRIORITY_EN
          if (best < 0 || m[i].age < m[best].age) best = i;
`else
          if (best < 0) best = i;
`endif
        end
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        picks.push_back(best);
        checkOutput($sformatf("issue_valid[%0d]", p), bus.issue_valid[p], 1'b1);
        checkOutput($sformatf("issue_T[%0d]", p), bus.issue_T[p], m[best].T);
        checkOutput($sformatf("issue_V1[%0d]", p), bus.issue_V1[p], m[best].v1);
        checkOutput($sformatf("issue_V2[%0d]", p), bus.issue_V2[p], m[best].v2);
        checkOutput($sformatf("issue_payload[%0d]", p), bus.issue_payload[p], m[best].pay);
      end else begin
        checkOutput($sformatf("issue_valid[%0d]", p), bus.issue_valid[p], 1'b0);
        checkOutput($sformatf("issue_data[%0d]", p),
                    {bus.issue_T[p], bus.issue_V1[p], bus.issue_V2[p]}, '0);
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    mEnt_t nm[RS_DEPTH];
    bit    taken[RS_DEPTH];
    bit [31:0] cv;
    int    fc = 0;
    nm = m;
    for (int i = 0; i < RS_DEPTH; i++) if (!m[i].valid) fc++;
    foreach (picks[q]) nm[picks[q]].valid = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (m[i].valid && !m[i].r1 && cdbHit(m[i].t1, cv)) begin
        nm[i].r1 = 1'b1;
        nm[i].v1 = cv;
      end
      if (m[i].valid && !m[i].r2 && cdbHit(m[i].t2, cv)) begin
        nm[i].r2 = 1'b1;
        nm[i].v2 = cv;
      end
    end
    if (fc >= DP_WIDTH) begin
      for (int k = 0; k < DP_WIDTH; k++) begin
        if (bus.dp_valid[k]) begin
          int e = -1;
          for (int i = RS_DEPTH - 1; i >= 0; i--) if (!m[i].valid && !taken[i]) e = i;
          taken[e]     = 1'b1;
          nm[e].valid  = 1'b1;
          nm[e].T      = bus.dp_T[k];
          nm[e].pay    = bus.dp_payload[k];
          nm[e].age    = ageCnt++;
          resolveSrc(k, 0, nm[e].r1, nm[e].t1, nm[e].v1);
          resolveSrc(k, 1, nm[e].r2, nm[e].t2, nm[e].v2);
        end
      end
    end
    if (bus.squash) begin
      for (int i = 0; i < RS_DEPTH; i++) nm[i].valid = 1'b0;
    end
    m = nm;
  endtask

  initial begin
    applyIdle();
    modelReset();
    #2 reset = 1'b0;
    #1 checkCycle();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(negedge clock);
      reset = 1'b1;
      if (cyc == NUM_CYCLES / 2) begin
        #1 reset = 1'b0;
        applyIdle();
        modelReset();
        #1 checkCycle();
        continue;
      end
      applyStimulus($urandom_range(0, 49) == 0);
      #1 checkCycle();
      modelStep();
    end
    @(negedge clock);
    applyIdle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
